seq_pattern_gen: RTL

Moore-style serial pattern transmitter: on a start request it shifts a fixed bit pattern (default 10110, MSB first) onto a one-bit line a programmable number of times. It is the stimulus/transmit end for the overlapping 10110 Moore detector (`moore_seq_10110_ov`). Repetitions are sent either back-to-back with shared overlap bits or separated by idle gap bits. The detector fires exactly once per repetition sent.

---
 rtl/seq_gen_pkg.sv | 27 ++
 rtl/seq_pattern_gen.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          MAX_PAT_W   = 32;
    localparam int          DEF_PAT_W   = 5;
    localparam logic [4:0]  DEF_PATTERN = 5'b10110;

    // Longest proper prefix of pat[w-1:0] that is also a suffix.
    function automatic int calc_ovl(input logic [MAX_PAT_W-1:0] pat, input int w);
        int ovl;
        logic [MAX_PAT_W-1:0] mask;
        ovl = 0;
        for (int l = 1; l < w; l++) begin
            mask = (MAX_PAT_W'(1) << l) - MAX_PAT_W'(1);
            if (((pat >> (w - l)) & mask) == (pat & mask)) ovl = l;
        end
        return ovl;
    endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial transmitter: shifts PATTERN (MSB first) out a programmable number of
// times, back-to-back with shared overlap bits or separated by idle gap bits.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN  = DEF_PATTERN,
    parameter int               CNT_W    = 4,
    parameter int               GAP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic             ov,
    output logic             out_seq,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int OVL   = calc_ovl(MAX_PAT_W'(PATTERN), PAT_W);
    localparam int IDX_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 1 - OVL);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic             ov_q, ov_n;
    logic             seq_d, valid_d, busy_d, done_d;

    // State and counters describe the bit currently on the line, so the
    // registered outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            rem_q     <= '0;
            ov_q      <= 1'b0;
            out_seq   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            gap_q     <= gap_n;
            rem_q     <= rem_n;
            ov_q      <= ov_n;
            out_seq   <= seq_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        gap_n   = gap_q;
        rem_n   = rem_q;
        ov_n    = ov_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        state_n = SHIFT;
                        idx_n   = IDX_TOP;
                        rem_n   = reps;
                        ov_n    = ov;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SHIFT: begin
                if (idx_q != '0) begin
                    idx_n = idx_q - 1'b1;
                end else begin
                    // rem counts repetitions including the one just finished,
                    // so it never wraps even at the maximum count.
                    rem_n = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_n = DONE;
                    end else if (ov_q) begin
                        idx_n = IDX_OVL;
                    end else if (GAP_BITS > 0) begin
                        state_n = GAP;
                        gap_n   = GAP_TOP;
                    end else begin
                        idx_n = IDX_TOP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_n = SHIFT;
                    idx_n   = IDX_TOP;
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        seq_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_n)
            SHIFT: begin
                seq_d   = PATTERN[idx_n];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            GAP: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

endmodule
